// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and sizing helper for reset_sequencer
package reset_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT  = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_SWHOLD  = 3'd3,
    ST_SWACK   = 3'd4
  } state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// rtl/reset_sequencer_sync.sv - async-assert / sync-deassert reset synchronizer chain
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with software reset handshake
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int STAGGER     = 8,
  parameter int HOLD        = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               sw_req,
  output logic               sw_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready
);

  localparam int CNT_W  = cnt_width(STAGGER);
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam int IDX_W  = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);

  logic                w_sync;
  state_t              r_state,       w_nxt_state;
  logic [CNT_W-1:0]    r_stagger_cnt, w_nxt_stagger_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt,    w_nxt_hold_cnt;
  logic [IDX_W-1:0]    r_idx,         w_nxt_idx;
  logic [NUM_OUT-1:0]  r_rst,         w_nxt_rst;
  logic                r_ready,       w_nxt_ready;
  logic                r_sw_ack,      w_nxt_sw_ack;
  logic                w_start;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk      (clk),
    .arst     (arst),
    .sync_out (w_sync)
  );

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_stagger_cnt = r_stagger_cnt;
    w_nxt_hold_cnt    = r_hold_cnt;
    w_nxt_idx         = r_idx;
    w_nxt_rst         = r_rst;
    w_nxt_ready       = r_ready;
    w_nxt_sw_ack      = r_sw_ack;
    w_start           = 1'b0;

    case (r_state)
      ST_ASSERT: begin
        if (w_sync) begin
          w_start = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (r_stagger_cnt == STAG_LAST) begin
          w_nxt_stagger_cnt = '0;
          w_nxt_rst         = r_rst & ~(NUM_OUT'(1) << r_idx);
          w_nxt_idx         = r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            w_nxt_ready = 1'b1;
            w_nxt_state = ST_RUN;
          end
        end else begin
          w_nxt_stagger_cnt = r_stagger_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (sw_req) begin
          w_nxt_rst      = '1;
          w_nxt_ready    = 1'b0;
          w_nxt_hold_cnt = '0;
          w_nxt_state    = ST_SWHOLD;
        end
      end
      ST_SWHOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_nxt_sw_ack = 1'b1;
          w_nxt_state  = ST_SWACK;
        end else begin
          w_nxt_hold_cnt = r_hold_cnt + 1'b1;
        end
      end
      ST_SWACK: begin
        if (!sw_req) begin
          w_nxt_sw_ack = 1'b0;
          w_start      = 1'b1;
        end
      end
      default: begin
        w_nxt_state  = ST_ASSERT;
        w_nxt_rst    = '1;
        w_nxt_ready  = 1'b0;
        w_nxt_sw_ack = 1'b0;
      end
    endcase

    // Both power-up and software paths release bit 0 on the entering edge.
    if (w_start) begin
      w_nxt_rst         = ~NUM_OUT'(1);
      w_nxt_stagger_cnt = '0;
      w_nxt_idx         = IDX_FIRST;
      if (NUM_OUT == 1) begin
        w_nxt_ready = 1'b1;
        w_nxt_state = ST_RUN;
      end else begin
        w_nxt_state = ST_RELEASE;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state       <= ST_ASSERT;
      r_stagger_cnt <= '0;
      r_hold_cnt    <= '0;
      r_idx         <= '0;
      r_rst         <= '1;
      r_ready       <= 1'b0;
      r_sw_ack      <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_stagger_cnt <= w_nxt_stagger_cnt;
      r_hold_cnt    <= w_nxt_hold_cnt;
      r_idx         <= w_nxt_idx;
      r_rst         <= w_nxt_rst;
      r_ready       <= w_nxt_ready;
      r_sw_ack      <= w_nxt_sw_ack;
    end
  end

  assign rst_out = r_rst;
  assign ready   = r_ready;
  assign sw_ack  = r_sw_ack;

endmodule
